mii_rx_deframer: RTL and testbench

- Front-end receive stage between the MII pins and the Ethernet header parser.
- Strips preamble/SFD, assembles nibbles into bytes (low nibble first) and checks the CRC-32 FCS.
- Removes the 4 FCS bytes and emits a byte stream with start/end markers and end-of-frame status.
- Keeps saturating good/bad frame counters for software.

---
 rtl/eth_pkg.sv | 22 ++
 rtl/crc32_byte.sv | 25 ++
 rtl/mii_rx_deframer.sv | 148 ++++++++++++++
 tb/tb_mii_rx_deframer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet receive-path types, framing constants and small helpers.
package eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } deframer_state_t;

  localparam logic [3:0]  PREAMBLE_NIBBLE      = 4'h5;
  localparam logic [3:0]  SFD_NIBBLE           = 4'hD;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE        = 32'hDEBB20E3;
  localparam int          DLY_BYTES            = 5;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational CRC-32 (reflected) advance by one byte, LSB first, no final inversion.
module crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  logic [31:0] w_crc;

  // Eight serial bit steps unrolled into one combinational stage.
  always_comb begin
    w_crc = i_crc;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0] ^ i_data[i]) begin
        w_crc = {1'b0, w_crc[31:1]} ^ CRC32_POLY_REFLECTED;
      end else begin
        w_crc = {1'b0, w_crc[31:1]};
      end
    end
    o_crc = w_crc;
  end

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, packs nibbles into bytes, checks FCS,
// hides the 4 FCS bytes behind a 5-byte delay line and counts good/bad frames.
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int MIN_FRAME_BYTES = 64
)(
  input  logic        rx_clk,
  input  logic        reset_n,
  input  logic [3:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_sof,
  output logic        out_eof,
  output logic        out_fcs_ok,
  output logic        out_err,
  output logic [15:0] good_frames,
  output logic [15:0] bad_frames
);

  localparam int            CW      = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME_BYTES);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_FRAME_BYTES);
  localparam logic [CW-1:0] DLY_CNT = CW'(DLY_BYTES);

  deframer_state_t r_state;
  logic            r_dv_prev;
  logic [3:0]      r_low_nib;
  logic            r_phase;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_crc;
  logic            r_err;
  logic [4:0][7:0] r_dly;

  logic [7:0]      w_byte;
  logic [31:0]     w_crc_next;
  logic            w_fcs_ok;
  logic            w_err_final;

  assign w_byte      = {rxd, r_low_nib};
  assign w_fcs_ok    = (r_crc == CRC32_RESIDUE);
  assign w_err_final = r_err | r_phase | (r_cnt < MIN_CNT);

  crc32_byte u_crc (
    .i_crc  (r_crc),
    .i_data (w_byte),
    .o_crc  (w_crc_next)
  );

  // Frame FSM with registered output strobes; r_dly[4] is always the oldest byte.
  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_dv_prev   <= 1'b1;  // forces a fresh rx_dv rise after reset
      r_low_nib   <= 4'h0;
      r_phase     <= 1'b0;
      r_cnt       <= '0;
      r_crc       <= CRC32_INIT;
      r_err       <= 1'b0;
      r_dly       <= '0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      out_fcs_ok  <= 1'b0;
      out_err     <= 1'b0;
      good_frames <= 16'h0000;
      bad_frames  <= 16'h0000;
    end else begin
      r_dv_prev  <= rx_dv;
      out_valid  <= 1'b0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_fcs_ok <= 1'b0;
      out_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (rx_dv) begin
            if (!r_dv_prev && (rxd == PREAMBLE_NIBBLE)) r_state <= PREAMBLE;
            else r_state <= DROP;
          end
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            r_state <= IDLE;
          end else if (rxd == SFD_NIBBLE) begin
            r_state <= DATA;
            r_crc   <= CRC32_INIT;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_phase <= 1'b0;
          end else if (rxd != PREAMBLE_NIBBLE) begin
            r_state <= DROP;
          end
        end
        DATA: begin
          if (!rx_dv) begin
            r_state <= IDLE;
            if (r_cnt >= DLY_CNT) begin
              out_valid  <= 1'b1;
              out_eof    <= 1'b1;
              out_sof    <= (r_cnt == DLY_CNT);
              out_data   <= r_dly[4];
              out_fcs_ok <= w_fcs_ok;
              out_err    <= w_err_final;
              if (w_fcs_ok && !w_err_final) good_frames <= sat_inc16(good_frames);
              else bad_frames <= sat_inc16(bad_frames);
            end else begin
              bad_frames <= sat_inc16(bad_frames);
            end
          end else begin
            if (rx_er) r_err <= 1'b1;
            if (!r_phase) begin
              r_low_nib <= rxd;
              r_phase   <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_crc   <= w_crc_next;
              r_dly   <= {r_dly[3:0], w_byte};
              r_cnt   <= r_cnt + CW'(1);
              if (r_cnt == MAX_CNT) begin
                // Oversize: close the frame now with an error, discard the rest.
                out_valid  <= 1'b1;
                out_eof    <= 1'b1;
                out_err    <= 1'b1;
                out_data   <= r_dly[4];
                bad_frames <= sat_inc16(bad_frames);
                r_state    <= DROP;
              end else if (r_cnt >= DLY_CNT) begin
                out_valid <= 1'b1;
                out_sof   <= (r_cnt == DLY_CNT);
                out_data  <= r_dly[4];
              end
            end
          end
        end
        DROP: begin
          if (!rx_dv) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Directed bench: frame-level reference model predicts every output strobe and counter.
module tb_mii_rx_deframer;

  localparam int MAXF = 100;
  localparam int MINF = 64;

  logic        rx_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rxd = 4'h0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid, out_sof, out_eof, out_fcs_ok, out_err;
  logic [15:0] good_frames, bad_frames;

  mii_rx_deframer #(.MAX_FRAME_BYTES(MAXF), .MIN_FRAME_BYTES(MINF)) dut (
    .rx_clk(rx_clk), .reset_n(reset_n), .rxd(rxd), .rx_dv(rx_dv), .rx_er(rx_er),
    .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_fcs_ok(out_fcs_ok), .out_err(out_err),
    .good_frames(good_frames), .bad_frames(bad_frames)
  );

  always #5 rx_clk = ~rx_clk;

  int          n_vec = 0, n_err = 0;
  logic [11:0] exp_arr [0:1023];
  int          wr = 0, rd = 0, n_seen = 0;
  int          exp_good = 0, exp_bad = 0, exp_seen_lit = 0;
  logic        endchk = 1'b0, rstchk = 1'b0;
  logic [11:0] got;
  logic [31:0] pin_crc;
  logic [7:0]  fr [$];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ({1'b0, r[31:1]} ^ 32'hEDB88320) : {1'b0, r[31:1]};
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, g, e);
    end
  endtask

  // Single compare process: every strobe against the model, plus end-of-frame checks.
  always @(negedge rx_clk) begin
    if (reset_n && out_valid) begin
      got = {out_data, out_sof, out_eof, out_eof & out_fcs_ok, out_eof & out_err};
      n_vec++;
      n_seen++;
      if (rd >= wr) begin
        n_err++;
        $display("FAIL unexpected_strobe got=%03h", got);
      end else begin
        if (got !== exp_arr[rd]) begin
          n_err++;
          $display("FAIL strobe[%0d] got=%03h exp=%03h", rd, got, exp_arr[rd]);
        end
        rd++;
      end
    end
    if (rstchk) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_eof", 32'(out_eof), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_good", 32'(good_frames), 32'd0);
      check("rst_bad", 32'(bad_frames), 32'd0);
      pin_crc = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) pin_crc = crc_upd(pin_crc, 8'(8'h31 + i));
      check("crc_pin", ~pin_crc, 32'hCBF43926);
    end
    if (endchk) begin
      check("leftover", 32'(rd), 32'(wr));
      check("strobes", 32'(n_seen), 32'(exp_seen_lit));
      check("good_frames", 32'(good_frames), 32'(exp_good));
      check("bad_frames", 32'(bad_frames), 32'(exp_bad));
      n_seen = 0;
    end
  end

  task automatic push(input logic [7:0] d, input logic s, input logic eo, input logic ok, input logic er);
    exp_arr[wr] = {d, s, eo, ok, er};
    wr++;
  endtask

  task automatic predict(input logic er, input logic extra);
    int n;
    logic [31:0] c;
    logic ok, e;
    n = fr.size();
    c = 32'hFFFFFFFF;
    if (n > MAXF) begin
      for (int k = 0; k <= MAXF - 5; k++) push(fr[k], k == 0, k == MAXF - 5, 1'b0, k == MAXF - 5);
      exp_bad++;
    end else if (n < 5) begin
      exp_bad++;
    end else begin
      foreach (fr[i]) c = crc_upd(c, fr[i]);
      ok = (c == 32'hDEBB20E3);
      e  = er || extra || (n < MINF);
      for (int k = 0; k <= n - 5; k++) push(fr[k], k == 0, k == n - 5, (k == n - 5) && ok, (k == n - 5) && e);
      if (ok && !e) exp_good++;
      else exp_bad++;
    end
  endtask

  task automatic build_good(input int npay);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    fr.delete();
    for (int i = 0; i < npay; i++) begin
      fr.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
  endtask

  task automatic drive(input logic [3:0] n, input logic dv, input logic er, input logic rst);
    @(posedge rx_clk);
    #1;
    reset_n = ~rst;
    rxd     = n;
    rx_dv   = dv;
    rx_er   = er;
  endtask

  task automatic send(input logic [3:0] last_pre, input int er_nib, input logic extra,
                      input int rst_nib, input int seen);
    logic [3:0] nib;
    for (int i = 0; i < 14; i++) drive(4'h5, 1'b1, 1'b0, 1'b0);
    drive(last_pre, 1'b1, 1'b0, 1'b0);
    drive(4'hD, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * fr.size(); i++) begin
      nib = i[0] ? fr[i/2][7:4] : fr[i/2][3:0];
      drive(nib, 1'b1, i == er_nib, i == rst_nib);
    end
    if (extra) drive(4'hA, 1'b1, 1'b0, 1'b0);
    repeat (12) drive(4'h0, 1'b0, 1'b0, 1'b0);
    exp_seen_lit = seen;
    @(posedge rx_clk); #1; endchk = 1'b1;
    @(posedge rx_clk); #1; endchk = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge rx_clk);
    #1; rstchk = 1'b1;
    @(posedge rx_clk); #1; rstchk = 1'b0; reset_n = 1'b1;
    repeat (3) @(posedge rx_clk);

    // good frame
    build_good(60); predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 60);
    // single payload bit flipped
    fr[10] = fr[10] ^ 8'h04; predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 60);
    // rx_er pulse mid-payload
    build_good(60); predict(1'b1, 1'b0);
    send(4'h5, 40, 1'b0, -1, 60);
    // dribble nibble
    predict(1'b0, 1'b1);
    send(4'h5, -1, 1'b1, -1, 60);
    // runt with valid FCS
    build_good(20); predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 20);
    // 3-byte frame
    fr.delete(); fr.push_back(8'h01); fr.push_back(8'h02); fr.push_back(8'h03);
    predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 0);
    // oversize
    fr.delete();
    for (int i = 0; i < 120; i++) fr.push_back(8'(i));
    predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 96);
    // corrupt preamble
    build_good(60);
    send(4'h7, -1, 1'b0, -1, 0);
    // reset pulse on the high nibble of byte 20: only bytes 0..14 escape
    for (int k = 0; k < 15; k++) push(fr[k], k == 0, 1'b0, 1'b0, 1'b0);
    exp_good = 0; exp_bad = 0;
    send(4'h5, -1, 1'b0, 41, 15);
    predict(1'b0, 1'b0);
    send(4'h5, -1, 1'b0, -1, 60);

    repeat (2) @(posedge rx_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
